// File: rtl/mux_lu_pkg.sv
// Shared types and constants for the mux-only logic unit (mux_logic_unit).
// Optional macro MUX_LU_ZERO_FLAG_EN is consumed by the top, not here.
package mux_lu_pkg;

    typedef enum logic [2:0] {
        OP_AND    = 3'd0,
        OP_OR     = 3'd1,
        OP_XOR    = 3'd2,
        OP_NAND   = 3'd3,
        OP_NOR    = 3'd4,
        OP_XNOR   = 3'd5,
        OP_PASS_A = 3'd6,
        OP_NOT_A  = 3'd7
    } op_e;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_ACC  = 1'b1
    } state_e;

    // Number of opcode functions feeding the final select tree.
    localparam int unsigned FN_NUM = 8;
    localparam int unsigned OP_W   = 3;

endpackage

// File: rtl/mux2_cell.sv
// Bitwise 2:1 multiplexer cell: each result bit picks d1 or d0 by its own sel bit.
module mux2_cell #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] sel,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d0,
    output logic [WIDTH-1:0] y
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign y[i] = sel[i] ? d1[i] : d0[i];
    end

endmodule

// File: rtl/mux_logic_unit.sv
// Registered bitwise logic unit built from mux2_cell; folds accumulate bursts.
// Optional build macro MUX_LU_ZERO_FLAG_EN adds the registered out_zero port.
module mux_logic_unit
    import mux_lu_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MAX_BEATS = 16,
    parameter int CNT_W     = $clog2(MAX_BEATS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    input  logic             in_acc,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic [CNT_W-1:0] out_count,
`ifdef MUX_LU_ZERO_FLAG_EN
    output logic             out_zero,
`endif
    output logic             dbg_state
);

    localparam logic [WIDTH-1:0] ZEROS = '0;
    localparam logic [WIDTH-1:0] ONES  = '1;

    state_e           state;
    op_e              op_l;
    logic [WIDTH-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;

    logic                          accept;
    logic [WIDTH-1:0]              opa;
    logic [WIDTH-1:0]              opb;
    logic [WIDTH-1:0]              nb;
    logic [OP_W-1:0]               fsel;
    logic [FN_NUM-1:0][WIDTH-1:0]  fn;
    logic [3:0][WIDTH-1:0]         lvl0;
    logic [1:0][WIDTH-1:0]         lvl1;
    logic [WIDTH-1:0]              fy;
    logic                          load_out;
    logic [CNT_W-1:0]              load_cnt;

    // Handshake: a beat transfers on in_valid && in_ready, a result on
    // out_valid && out_ready; in_ready only depends on the output slot
    // freeing up this cycle, so it holds in both IDLE and ACC.
    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;
    assign dbg_state = state;
    assign cnt_next  = cnt + CNT_W'(1);

    // Inside a burst the running accumulator takes operand A's place.
    assign opa  = (state == ST_ACC) ? acc  : in_a;
    assign opb  = (state == ST_ACC) ? in_a : in_b;
    assign fsel = (state == ST_ACC) ? op_l : in_op;

    mux2_cell #(.WIDTH(WIDTH)) u_nb   (.sel(opb), .d1(ZEROS), .d0(ONES),  .y(nb));
    mux2_cell #(.WIDTH(WIDTH)) u_and  (.sel(opa), .d1(opb),   .d0(ZEROS), .y(fn[0]));
    mux2_cell #(.WIDTH(WIDTH)) u_or   (.sel(opa), .d1(ONES),  .d0(opb),   .y(fn[1]));
    mux2_cell #(.WIDTH(WIDTH)) u_xor  (.sel(opa), .d1(nb),    .d0(opb),   .y(fn[2]));
    mux2_cell #(.WIDTH(WIDTH)) u_nand (.sel(opa), .d1(nb),    .d0(ONES),  .y(fn[3]));
    mux2_cell #(.WIDTH(WIDTH)) u_nor  (.sel(opa), .d1(ZEROS), .d0(nb),    .y(fn[4]));
    mux2_cell #(.WIDTH(WIDTH)) u_xnor (.sel(opa), .d1(opb),   .d0(nb),    .y(fn[5]));
    mux2_cell #(.WIDTH(WIDTH)) u_pass (.sel(opa), .d1(ONES),  .d0(ZEROS), .y(fn[6]));
    mux2_cell #(.WIDTH(WIDTH)) u_nota (.sel(opa), .d1(ZEROS), .d0(ONES),  .y(fn[7]));

    // Opcode select as a three-level binary mux tree, LSB first.
    for (genvar i = 0; i < 4; i++) begin : g_lvl0
        mux2_cell #(.WIDTH(WIDTH)) u_m (
            .sel({WIDTH{fsel[0]}}), .d1(fn[2*i+1]), .d0(fn[2*i]), .y(lvl0[i])
        );
    end
    for (genvar i = 0; i < 2; i++) begin : g_lvl1
        mux2_cell #(.WIDTH(WIDTH)) u_m (
            .sel({WIDTH{fsel[1]}}), .d1(lvl0[2*i+1]), .d0(lvl0[2*i]), .y(lvl1[i])
        );
    end
    mux2_cell #(.WIDTH(WIDTH)) u_top (
        .sel({WIDTH{fsel[2]}}), .d1(lvl1[1]), .d0(lvl1[0]), .y(fy)
    );

    always_comb begin
        load_out = 1'b0;
        load_cnt = CNT_W'(1);
        if (accept) begin
            if (state == ST_IDLE) begin
                load_out = !in_acc || in_last || (MAX_BEATS == 1);
            end else begin
                load_out = in_last || (cnt_next == CNT_W'(MAX_BEATS));
                load_cnt = cnt_next;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            op_l      <= OP_AND;
            acc       <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_y     <= '0;
            out_count <= '0;
`ifdef MUX_LU_ZERO_FLAG_EN
            out_zero  <= 1'b0;
`endif
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (load_out) begin
                out_y     <= fy;
                out_count <= load_cnt;
                out_valid <= 1'b1;
                state     <= ST_IDLE;
`ifdef MUX_LU_ZERO_FLAG_EN
                out_zero  <= (fy == ZEROS);
`endif
            end else if (accept) begin
                acc <= fy;
                if (state == ST_IDLE) begin
                    op_l  <= op_e'(in_op);
                    cnt   <= CNT_W'(1);
                    state <= ST_ACC;
                end else begin
                    cnt <= cnt_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_mux_logic_unit.sv
// Self-checking bench for mux_logic_unit (MAX_BEATS=4); honours MUX_LU_ZERO_FLAG_EN.
module tb_mux_logic_unit;

    localparam int W    = 8;
    localparam int MAXB = 4;
    localparam int CW   = $clog2(MAXB + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_a = '0;
    logic [W-1:0]  in_b = '0;
    logic [2:0]    in_op = '0;
    logic          in_acc = 1'b0;
    logic          in_last = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  out_y;
    logic [CW-1:0] out_count;
    logic          dbg_state;
`ifdef MUX_LU_ZERO_FLAG_EN
    logic          out_zero;
`endif

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic          m_valid;
    logic [W-1:0]  m_y;
    logic [CW-1:0] m_cnt;
    logic          m_zero;
    logic          m_busy;
    logic [2:0]    m_op;
    logic [W-1:0]  burst_q[$];
    logic [W-1:0]  exp_q[$];

    mux_logic_unit #(.WIDTH(W), .MAX_BEATS(MAXB)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op),
        .in_acc(in_acc), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_y(out_y), .out_count(out_count),
`ifdef MUX_LU_ZERO_FLAG_EN
        .out_zero(out_zero),
`endif
        .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    function automatic logic [W-1:0] ref_f(input logic [2:0] op, input logic [W-1:0] x,
                                           input logic [W-1:0] y);
        case (op)
            3'd0:    return x & y;
            3'd1:    return x | y;
            3'd2:    return x ^ y;
            3'd3:    return ~(x & y);
            3'd4:    return ~(x | y);
            3'd5:    return ~(x ^ y);
            3'd6:    return x;
            default: return ~x;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
        total++;
        if (got !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, expv, $time);
        end
    endtask

    // ---------------- reference model ----------------
    task automatic model_emit(input logic [W-1:0] res, input int n);
        m_y     = res;
        m_cnt   = CW'(n);
        m_zero  = (res == '0);
        m_valid = 1'b1;
        exp_q.push_back(res);
    endtask

    initial begin
        logic          take;
        logic [W-1:0]  r;
        m_valid = 0; m_y = '0; m_cnt = '0; m_zero = 0; m_busy = 0; m_op = '0;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_valid = 0; m_y = '0; m_cnt = '0; m_zero = 0; m_busy = 0; m_op = '0;
                burst_q.delete();
                exp_q.delete();
            end else begin
                take = in_valid && (!m_valid || out_ready);
                if (m_valid && out_ready) m_valid = 1'b0;
                if (take) begin
                    if (!m_busy) begin
                        if (!in_acc || in_last || MAXB == 1) begin
                            model_emit(ref_f(in_op, in_a, in_b), 1);
                        end else begin
                            m_busy = 1'b1;
                            m_op   = in_op;
                            burst_q.delete();
                            burst_q.push_back(ref_f(in_op, in_a, in_b));
                        end
                    end else begin
                        burst_q.push_back(in_a);
                        if (in_last || burst_q.size() == MAXB) begin
                            r = burst_q[0];
                            for (int i = 1; i < burst_q.size(); i++) r = ref_f(m_op, r, burst_q[i]);
                            model_emit(r, burst_q.size());
                            m_busy = 1'b0;
                            burst_q.delete();
                        end
                    end
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        check("out_valid", 32'(out_valid), 32'(m_valid));
        check("in_ready", 32'(in_ready), 32'(!m_valid || out_ready));
        check("out_y", 32'(out_y), 32'(m_y));
        check("out_count", 32'(out_count), 32'(m_cnt));
        check("state", 32'(dbg_state), 32'(m_busy));
`ifdef MUX_LU_ZERO_FLAG_EN
        check("out_zero", 32'(out_zero), 32'(m_zero));
`endif
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) check("xfer_unexpected", 32'(out_y), 32'hDEAD_BEEF);
            else check("xfer_y", 32'(out_y), 32'(exp_q.pop_front()));
        end
    end

    // ---------------- driver ----------------
    // Entered and left at posedge+1; returns just after the accepting edge.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op,
                        input logic acc, input logic last);
        int guard = 0;
        in_valid = 1'b1; in_a = a; in_b = b; in_op = op; in_acc = acc; in_last = last;
        @(negedge clk);
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) check("send_timeout", 32'(guard), 32'(0));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed + random stimulus ----------------
    initial begin
        logic [W-1:0] t1_exp[8];
        t1_exp = '{8'h88, 8'hEE, 8'h66, 8'h77, 8'h11, 8'h99, 8'hCC, 8'h33};

        repeat (3) step();
        check("rst_valid", 32'(out_valid), 32'(0));
        check("rst_y", 32'(out_y), 32'(0));
        check("rst_count", 32'(out_count), 32'(0));
        rst = 1'b0;
        step();

        // All eight opcodes back to back
        out_ready = 1'b1;
        for (int op = 0; op < 8; op++) begin
            send(8'hCC, 8'hAA, 3'(op), 1'b0, 1'b0);
            check($sformatf("t1_y_op%0d", op), 32'(out_y), 32'(t1_exp[op]));
            check($sformatf("t1_cnt_op%0d", op), 32'(out_count), 32'(1));
            check($sformatf("t1_vld_op%0d", op), 32'(out_valid), 32'(1));
        end

        // Output hold under back-pressure
        step();
        out_ready = 1'b0;
        send(8'hF0, 8'h3C, 3'd0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check("t2_hold_y", 32'(out_y), 32'h30);
            check("t2_hold_rdy", 32'(in_ready), 32'(0));
            step();
        end
        out_ready = 1'b1;
        #1;
        check("t2_rdy_release", 32'(in_ready), 32'(1));
        step();
        check("t2_drained", 32'(out_valid), 32'(0));
        check("t2_y_kept", 32'(out_y), 32'h30);

        // Accumulate AND over three beats
        send(8'hA5, 8'hFF, 3'd0, 1'b1, 1'b0);
        send(8'h0F, 8'h00, 3'd5, 1'b0, 1'b0);
        send(8'h3C, 8'h00, 3'd1, 1'b1, 1'b1);
        check("t3_y", 32'(out_y), 32'h04);
        check("t3_cnt", 32'(out_count), 32'(3));

        // Forced close at MAX_BEATS
        send(8'h01, 8'h00, 3'd2, 1'b1, 1'b0);
        send(8'h02, 8'h00, 3'd0, 1'b1, 1'b0);
        send(8'h04, 8'h00, 3'd0, 1'b1, 1'b0);
        check("t4_mid_state", 32'(dbg_state), 32'(1));
        send(8'h08, 8'h00, 3'd0, 1'b1, 1'b0);
        check("t4_y", 32'(out_y), 32'h0F);
        check("t4_cnt", 32'(out_count), 32'(4));
        check("t4_state", 32'(dbg_state), 32'(0));
        send(8'hCC, 8'hAA, 3'd0, 1'b0, 1'b0);
        check("t4_next_y", 32'(out_y), 32'h88);
        check("t4_next_cnt", 32'(out_count), 32'(1));

        // Reset in the middle of a burst
        send(8'h11, 8'h22, 3'd1, 1'b1, 1'b0);
        send(8'h44, 8'h00, 3'd1, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #2;
        check("t5_rst_valid", 32'(out_valid), 32'(0));
        check("t5_rst_y", 32'(out_y), 32'(0));
        check("t5_rst_state", 32'(dbg_state), 32'(0));
        step();
        rst = 1'b0;
        send(8'hFF, 8'h0F, 3'd0, 1'b0, 1'b0);
        check("t5_y", 32'(out_y), 32'h0F);
        check("t5_cnt", 32'(out_count), 32'(1));
`ifdef MUX_LU_ZERO_FLAG_EN
        send(8'hF0, 8'h0F, 3'd0, 1'b0, 1'b0);
        check("t5_zero", 32'(out_zero), 32'(1));
`endif

        // No bubble on simultaneous output accept and new result
        send(8'hCC, 8'hAA, 3'd2, 1'b0, 1'b0);
        check("t6_first_vld", 32'(out_valid), 32'(1));
        check("t6_first_y", 32'(out_y), 32'h66);
        send(8'h0F, 8'hF0, 3'd1, 1'b0, 1'b0);
        check("t6_second_vld", 32'(out_valid), 32'(1));
        check("t6_second_y", 32'(out_y), 32'hFF);

        // Random phase, checked every cycle against the model
        for (int c = 0; c < 1500; c++) begin
            step();
            rst       = ($urandom_range(0, 299) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_a      = W'($urandom_range(0, 255));
            in_b      = W'($urandom_range(0, 255));
            in_op     = 3'($urandom_range(0, 7));
            in_acc    = ($urandom_range(0, 2) != 0);
            in_last   = ($urandom_range(0, 3) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
        end
        step();
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
